// File: rtl/dm_rmw_unit.sv
// Data-memory responder: word-organised RAM serving word/half/byte loads and stores,
// with sub-word stores done as read-modify-write behind a req/done handshake.
module dm_rmw_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        choice,
  input  logic [2:0]        ld_sel,
  input  logic [ADDR_W+1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  // Handshake: req is sampled only in IDLE; the accepted command is latched at that
  // edge, and done pulses high for the single DONE cycle with rdata/err valid.
  state_t              state_q;
  logic                we_q;
  logic [1:0]          choice_q;
  logic [2:0]          ld_sel_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic [31:0]         rdata_q;

  logic [31:0]         mem [0:(2**ADDR_W)-1];

  logic                st_word, st_half, ld_word, ld_half, misalign;
  logic [31:0]         rd_word, ext_word, merge_word;
  logic [7:0]          rd_byte;
  logic [15:0]         rd_half;
  logic [4:0]          byte_off, half_off;

  // Alignment is judged on the live inputs, since it is only needed on the accepting edge.
  always_comb begin
    st_word  = (choice == 2'b00) || (choice == 2'b11);
    st_half  = (choice == 2'b10);
    ld_half  = (ld_sel == 3'b100) || (ld_sel == 3'b110);
    ld_word  = !(ld_half || (ld_sel == 3'b011) || (ld_sel == 3'b101));
    misalign = we ? ((st_half && addr[0]) || (st_word && (addr[1:0] != 2'b00)))
                  : ((ld_half && addr[0]) || (ld_word && (addr[1:0] != 2'b00)));
  end

  always_comb begin
    byte_off = {addr_q[1:0], 3'b000};
    half_off = {addr_q[1], 4'b0000};
    rd_word  = mem[addr_q[ADDR_W+1:2]];
    rd_byte  = rd_word[byte_off +: 8];
    rd_half  = rd_word[half_off +: 16];
    case (ld_sel_q)
      3'b011:  ext_word = {{24{rd_byte[7]}}, rd_byte};
      3'b101:  ext_word = {24'h0, rd_byte};
      3'b100:  ext_word = {{16{rd_half[15]}}, rd_half};
      3'b110:  ext_word = {16'h0, rd_half};
      default: ext_word = rd_word;
    endcase
    merge_word = rd_word;
    if (choice_q == 2'b01) merge_word[byte_off +: 8]  = wdata_q[7:0];
    else                   merge_word[half_off +: 16] = wdata_q[15:0];
  end

  // RAM is never reset; an async reset drops the FSM out of WR so no write follows.
  always_ff @(posedge clk) begin
    if (state_q == WR) mem[addr_q[ADDR_W+1:2]] <= wdata_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      choice_q <= 2'b00;
      ld_sel_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      case (state_q)
        IDLE: if (req) begin
          we_q     <= we;
          choice_q <= choice;
          ld_sel_q <= ld_sel;
          addr_q   <= addr;
          wdata_q  <= wdata;
          busy_q   <= 1'b1;
          if (misalign) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else if (we && st_word) begin
            state_q <= WR;
          end else begin
            state_q <= RD;
          end
        end
        RD: if (we_q) begin
          wdata_q <= merge_word;
          state_q <= WR;
        end else begin
          rdata_q <= ext_word;
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        WR: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign dbg_state = state_q;

endmodule
